bit_serial_alu: RTL and testbench

//  Bit-serial ALU datapath. It consumes the per-bit logic-extender function (M,s1,s0,ai,bi -> xi)
//  and adds an arithmetic extender, a full adder and a carry flip-flop.
//  It processes WIDTH-bit operands LSB-first, one bit per clock, under a small control FSM.
//  It sits directly downstream of the logic extender slice and produces the registered result word and flags.

---
 rtl/bit_serial_alu.sv | 175 +++++++++++++++++
 tb/tb_bit_serial_alu.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: logic/arith extenders, full adder and carry FF, LSB-first, one bit per clock.
// Optional signed-overflow flag via ALU_OVERFLOW_EN.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             M,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic             cout,
  output logic             zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, x_q, x_d;
  logic [1:0]       op_q, op_d;
  logic             m_q, m_d, c_q, c_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, zero_q, zero_d;
`ifdef ALU_OVERFLOW_EN
  logic             ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
`endif

  logic ai_c, bi_c, xi_c, yi_c, fi_c, co_c, c0_c;

  // Per-bit slice: logic extender, arithmetic extender, full adder.
  always_comb begin
    ai_c = a_q[0];
    bi_c = b_q[0];
    xi_c = ai_c;
    yi_c = 1'b0;
    if (m_q) begin
      unique case (op_q)
        2'b00:   xi_c = ~ai_c;
        2'b01:   xi_c = ai_c & bi_c;
        2'b10:   xi_c = ai_c | bi_c;
        default: xi_c = ai_c ^ bi_c;
      endcase
    end else begin
      unique case (op_q)
        2'b00:   yi_c = bi_c;
        2'b01:   yi_c = ~bi_c;
        2'b10:   yi_c = 1'b0;
        default: yi_c = 1'b1;
      endcase
    end
    fi_c = xi_c ^ yi_c ^ c_q;
    co_c = (xi_c & yi_c) | (xi_c & c_q) | (yi_c & c_q);
    // Initial carry comes from the incoming op code, loaded at accept time.
    c0_c = ~M & (s1 ^ s0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    m_d     = m_q;
    c_d     = c_q;
    x_d     = x_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
`ifdef ALU_OVERFLOW_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif
    busy_d  = (state_q != S_IDLE);
    done_d  = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        // busy_q still high during the done cycle, so a start there is dropped.
        if (start && !busy_q) begin
          a_d     = a;
          b_d     = b;
          m_d     = M;
          op_d    = {s1, s0};
          c_d     = c0_c;
          cnt_d   = '0;
          r_d     = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {fi_c, r_q[WIDTH-1:1]};
        c_d   = co_c;
`ifdef ALU_OVERFLOW_EN
        ovf_pend_d = c_q ^ co_c;
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        x_d     = r_q;
        cout_d  = ~m_q & c_q;
        zero_d  = (r_q == '0);
`ifdef ALU_OVERFLOW_EN
        ovf_d   = ~m_q & ovf_pend_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= '0;
      m_q     <= 1'b0;
      c_q     <= 1'b0;
      x_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      m_q     <= m_d;
      c_q     <= c_d;
      x_q     <= x_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ALU_OVERFLOW_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign x    = x_q;
  assign cout = cout_q;
  assign zero = zero_q;
`ifdef ALU_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu (WIDTH=8): op table, start-while-busy, mid-op reset.
module tb_bit_serial_alu;

  logic       clk = 1'b0;
  logic       rst, start, M, s1, s0;
  logic [7:0] a, b, x;
  logic       busy, done, cout, zero;
`ifdef ALU_OVERFLOW_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  bit_serial_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .s1(s1), .s0(s0),
    .a(a), .b(b), .busy(busy), .done(done), .x(x), .cout(cout), .zero(zero)
`ifdef ALU_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [1:0] s;
    logic [7:0] a, b, x;
    logic       cout, zero, ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at edge 0; inject>0 re-pulses start with other operands after that edge.
  task automatic run_op(input vec_t v, input int inject, input string tag);
    int done_cyc = 0, done_cnt = 0, busy_cnt = 0, n = 0;
    M = v.m; {s1, s0} = v.s; a = v.a; b = v.b; start = 1'b1;
    step();
    start = 1'b0;
    for (n = 1; n <= 20; n++) begin
      step();
      if (n == inject) begin
        start = 1'b1; M = 1'b1; {s1, s0} = 2'b10; a = 8'h11; b = 8'h22;
      end else begin
        start = 1'b0;
      end
      if (done) begin done_cnt++; done_cyc = n; end
      if (busy) busy_cnt++;
      else break;
    end
    check({tag, ".latency"}, 32'(done_cyc), 32'd9);
    check({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, ".busy_cnt"}, 32'(busy_cnt), 32'd9);
    check({tag, ".x"}, 32'(x), 32'(v.x));
    check({tag, ".cout"}, 32'(cout), 32'(v.cout));
    check({tag, ".zero"}, 32'(zero), 32'(v.zero));
`ifdef ALU_OVERFLOW_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(v.ovf));
`endif
    step();
    step();
    check({tag, ".idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'b11, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 8'hC3, 8'h5A, 8'h1D, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 8'hC3, 8'h5A, 8'h69, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 2'b10, 8'hC3, 8'h5A, 8'hC4, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 8'hC3, 8'h5A, 8'hC2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 8'hC3, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'b10, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'b11, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; M = 1'b0; s1 = 1'b0; s0 = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.x", 32'(x), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
`ifdef ALU_OVERFLOW_EN
    check("rst.ovf", 32'(ovf), 32'd0);
`endif

    for (int i = 0; i < 13; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    run_op(vecs[0], 3, "restart_ignored");

    // Mid-operation reset: x holds 0x80 beforehand, so x==0 shows the abort.
    begin
      int done_seen = 0;
      M = 1'b0; {s1, s0} = 2'b00; a = 8'hC3; b = 8'h5A; start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 4; n++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.x", 32'(x), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      for (int n = 0; n < 15; n++) begin
        step();
        if (done || busy) done_seen++;
      end
      check("abort.no_done", 32'(done_seen), 32'd0);
    end

    run_op(vecs[5], 0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
